// File: rtl/debug_mem_dumper_if.sv
// Debug dump bus: memory debug read port plus byte-transmit handshake.
//   mem_addr  master->slave  word address for the memory debug port
//   mem_data  slave->master  word returned by the memory debug port
//   tx_start  master->slave  one-cycle pulse, tx_data valid
//   tx_data   master->slave  byte to transmit, held until tx_done
//   tx_done   slave->master  one-cycle pulse, byte finished
interface debug_mem_dumper_if #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_BYTE = 8
);
    logic [NB_DATA-1:0] mem_addr;
    logic [NB_DATA-1:0] mem_data;
    logic               tx_start;
    logic [NB_BYTE-1:0] tx_data;
    logic               tx_done;

    modport master (
        output mem_addr, tx_start, tx_data,
        input  mem_data, tx_done
    );

    modport slave (
        input  mem_addr, tx_start, tx_data,
        output mem_data, tx_done
    );
endinterface

// File: rtl/debug_mem_dumper.sv
// Walks word addresses 0..N_WORDS-1 on the data-memory debug port and streams every
// word out little-endian as bytes over a start/done transmit handshake.
//   i_clk    system clock, rising edge
//   i_rst    synchronous reset, active high; aborts a dump in progress
//   i_start  dump request, sampled only when idle
//   dbg      debug bus (memory address/data, tx_start/tx_data/tx_done)
//   o_busy   high while a dump is in progress (through the done cycle)
//   o_done   one-cycle pulse after the last byte has been transmitted
module debug_mem_dumper #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_BYTE = 8,
    parameter int unsigned N_WORDS = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    debug_mem_dumper_if.master dbg,
    output logic               o_busy,
    output logic               o_done
);
    localparam int unsigned NBytes = NB_DATA / NB_BYTE;
    localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;
    localparam int unsigned CntW   = $clog2(N_WORDS) + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBytes - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(N_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle, StAddr, StLatch, StSend, StWaitTx, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] addr_q, addr_d;
    logic [NB_DATA-1:0] word_q, word_d;
    logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               tx_start;
    logic               done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            word_q    <= '0;
            tx_data_q <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            word_q    <= word_d;
            tx_data_q <= tx_data_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    // The outgoing byte is loaded on the transition into SEND so that it is already
    // valid in the cycle tx_start pulses; word_q is shifted so the next byte sits in
    // its second byte lane.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        word_d    = word_q;
        tx_data_d = tx_data_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tx_start  = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = StAddr;
                end
            end
            // Settling cycle for a combinational or 1-cycle registered debug read.
            StAddr: state_d = StLatch;
            StLatch: begin
                word_d    = dbg.mem_data;
                tx_data_d = dbg.mem_data[NB_BYTE-1:0];
                idx_d     = '0;
                state_d   = StSend;
            end
            StSend: begin
                tx_start = 1'b1;
                state_d  = StWaitTx;
            end
            StWaitTx: begin
                if (dbg.tx_done) begin
                    if (idx_q != LastIdx) begin
                        idx_d     = idx_q + 1'b1;
                        word_d    = word_q >> NB_BYTE;
                        tx_data_d = word_q[2*NB_BYTE-1:NB_BYTE];
                        state_d   = StSend;
                    end else if (cnt_q == LastCnt) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                        state_d = StAddr;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign dbg.mem_addr = addr_q;
    assign dbg.tx_start = tx_start;
    assign dbg.tx_data  = tx_data_q;
    assign o_busy       = (state_q != StIdle);
    assign o_done       = done;
endmodule

// File: tb/tb_debug_mem_dumper.sv
module tb_debug_mem_dumper;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: two words ----------------
    logic        start_a, busy_a, done_a, xdone_a;
    logic [31:0] mem_a [2];
    int          dly_a;
    logic [3:0]  cd_a = '0;
    debug_mem_dumper_if #(.NB_DATA(32), .NB_BYTE(8)) bus_a ();
    debug_mem_dumper #(.NB_DATA(32), .NB_BYTE(8), .N_WORDS(2)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .dbg(bus_a.master),
        .o_busy(busy_a), .o_done(done_a)
    );
    assign bus_a.mem_data = mem_a[bus_a.mem_addr[0]];
    // Transmitter model: tx_done dly_a cycles after the tx_start cycle.
    always @(posedge clk) begin
        if (rst) cd_a <= '0;
        else if (bus_a.tx_start) cd_a <= 4'(dly_a);
        else if (cd_a != 0) cd_a <= cd_a - 1'b1;
    end
    assign bus_a.tx_done = (cd_a == 4'd1) | xdone_a;

    logic [7:0]  obs_a [$];
    logic [31:0] oaddr_a [$];
    int          scyc_a [$];
    logic [7:0]  exp_a [$];
    logic [31:0] eaddr_a [$];
    int          starts_a = 0, dones_a = 0, hold_err_a = 0;
    logic [7:0]  last_a = '0;
    always @(negedge clk) begin
        if (bus_a.tx_start) begin
            obs_a.push_back(bus_a.tx_data);
            oaddr_a.push_back(bus_a.mem_addr);
            scyc_a.push_back(cyc);
            starts_a++;
            last_a = bus_a.tx_data;
        end else if (cd_a != 0 && bus_a.tx_data !== last_a) begin
            hold_err_a++;
        end
        if (done_a) dones_a++;
    end

    // ---------------- instance B: one word ----------------
    logic        start_b, busy_b, done_b;
    logic [31:0] mem_b;
    logic [3:0]  cd_b = '0;
    debug_mem_dumper_if #(.NB_DATA(32), .NB_BYTE(8)) bus_b ();
    debug_mem_dumper #(.NB_DATA(32), .NB_BYTE(8), .N_WORDS(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .dbg(bus_b.master),
        .o_busy(busy_b), .o_done(done_b)
    );
    assign bus_b.mem_data = mem_b;
    always @(posedge clk) begin
        if (rst) cd_b <= '0;
        else if (bus_b.tx_start) cd_b <= 4'd2;
        else if (cd_b != 0) cd_b <= cd_b - 1'b1;
    end
    assign bus_b.tx_done = (cd_b == 4'd1);

    logic [7:0] obs_b [$];
    logic [7:0] exp_b [$];
    int         starts_b = 0, dones_b = 0, last_txd_b = -1, done_cyc_b = -1;
    always @(negedge clk) begin
        if (bus_b.tx_start) begin
            obs_b.push_back(bus_b.tx_data);
            starts_b++;
        end
        if (bus_b.tx_done) last_txd_b = cyc;
        if (done_b) begin
            dones_b++;
            done_cyc_b = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        obs_a.delete(); oaddr_a.delete(); scyc_a.delete();
        exp_a.delete(); eaddr_a.delete();
        starts_a = 0; dones_a = 0; hold_err_a = 0;
    endtask

    task automatic push_exp_a();
        for (int w = 0; w < 2; w++)
            for (int b = 0; b < 4; b++) begin
                exp_a.push_back(mem_a[w][8*b +: 8]);
                eaddr_a.push_back(32'(w));
            end
    endtask

    task automatic test_reset();
        rst = 1'b1; xdone_a = 1'b1;
        tick(); xdone_a = 1'b0; tick();
        n_checks++; if (bus_a.mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr_a got %h exp 0", bus_a.mem_addr); end
        n_checks++; if (bus_a.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start_a got %b exp 0", bus_a.tx_start); end
        n_checks++; if (bus_a.tx_data !== 8'd0) begin n_fail++; $display("FAIL reset_tx_data_a got %h exp 0", bus_a.tx_data); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a got %b exp 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done_a got %b exp 0", done_a); end
        n_checks++; if (bus_b.mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr_b got %h exp 0", bus_b.mem_addr); end
        n_checks++; if (bus_b.tx_data !== 8'd0) begin n_fail++; $display("FAIL reset_tx_data_b got %h exp 0", bus_b.tx_data); end
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b got %b exp 0", busy_b); end
        rst = 1'b0; xdone_a = 1'b1;
        tick(); xdone_a = 1'b0;
        repeat (3) tick();
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL idle_done_ignored_busy got %b exp 0", busy_a); end
        n_checks++; if (starts_a != 0) begin n_fail++; $display("FAIL idle_done_ignored_starts got %0d exp 0", starts_a); end
        n_checks++; if (dones_a != 0) begin n_fail++; $display("FAIL idle_done_ignored_dones got %0d exp 0", dones_a); end
    endtask

    task automatic test_slow_tx();
        dly_a = 3; clear_a(); push_exp_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL slow_busy_after_start got %b exp 1", busy_a); end
        for (int i = 0; i < 300 && dones_a == 0; i++) tick();
        n_checks++; if (dones_a == 0) begin n_fail++; $display("FAIL slow_timeout got no done exp done"); end
        repeat (3) tick();
        n_checks++; if (dones_a != 1) begin n_fail++; $display("FAIL slow_done_pulses got %0d exp 1", dones_a); end
        n_checks++; if (starts_a != 8) begin n_fail++; $display("FAIL slow_tx_starts got %0d exp 8", starts_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL slow_busy_end got %b exp 0", busy_a); end
        n_checks++; if (bus_a.mem_addr !== 32'd1) begin n_fail++; $display("FAIL slow_addr_hold got %h exp 1", bus_a.mem_addr); end
        n_checks++; if (hold_err_a != 0) begin n_fail++; $display("FAIL slow_data_hold got %0d changes exp 0", hold_err_a); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e; logic [31:0] ea;
            e = exp_a.pop_front(); ea = eaddr_a.pop_front();
            n_checks++;
            if (obs_a.size() == 0) begin n_fail++; $display("FAIL slow_byte%0d got none exp %h", i, e); end
            else begin
                logic [7:0] g; logic [31:0] ga;
                g = obs_a.pop_front(); ga = oaddr_a.pop_front();
                if (g !== e || ga !== ea) begin n_fail++; $display("FAIL slow_byte%0d got %h@%h exp %h@%h", i, g, ga, e, ea); end
            end
        end
    endtask

    task automatic test_fast_tx();
        dly_a = 1; clear_a(); push_exp_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int i = 0; i < 300 && dones_a == 0; i++) tick();
        n_checks++; if (dones_a == 0) begin n_fail++; $display("FAIL fast_timeout got no done exp done"); end
        repeat (3) tick();
        n_checks++; if (starts_a != 8) begin n_fail++; $display("FAIL fast_tx_starts got %0d exp 8", starts_a); end
        for (int i = 1; i < 8 && i < scyc_a.size(); i++) begin
            int gap; gap = (i == 4) ? 4 : 2;
            n_checks++;
            if (scyc_a[i] - scyc_a[i-1] != gap) begin n_fail++; $display("FAIL fast_period%0d got %0d exp %0d", i, scyc_a[i] - scyc_a[i-1], gap); end
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e; logic [31:0] ea;
            e = exp_a.pop_front(); ea = eaddr_a.pop_front();
            n_checks++;
            if (obs_a.size() == 0) begin n_fail++; $display("FAIL fast_byte%0d got none exp %h", i, e); end
            else begin
                logic [7:0] g; logic [31:0] ga;
                g = obs_a.pop_front(); ga = oaddr_a.pop_front();
                if (g !== e || ga !== ea) begin n_fail++; $display("FAIL fast_byte%0d got %h@%h exp %h@%h", i, g, ga, e, ea); end
            end
        end
    endtask

    task automatic test_ignored();
        dly_a = 3; clear_a(); push_exp_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        // Spurious start while busy; spurious tx_done outside WAIT_TX.
        for (int i = 0; i < 300 && dones_a == 0; i++) begin
            start_a = busy_a && (i % 3 == 0);
            xdone_a = busy_a && (cd_a == 0);
            tick();
        end
        start_a = 1'b0; xdone_a = 1'b0;
        n_checks++; if (dones_a == 0) begin n_fail++; $display("FAIL ignore_timeout got no done exp done"); end
        repeat (4) tick();
        n_checks++; if (starts_a != 8) begin n_fail++; $display("FAIL ignore_tx_starts got %0d exp 8", starts_a); end
        n_checks++; if (dones_a != 1) begin n_fail++; $display("FAIL ignore_done_pulses got %0d exp 1", dones_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart got busy %b exp 0", busy_a); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e;
            e = exp_a.pop_front();
            n_checks++;
            if (obs_a.size() == 0) begin n_fail++; $display("FAIL ignore_byte%0d got none exp %h", i, e); end
            else begin
                logic [7:0] g;
                g = obs_a.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL ignore_byte%0d got %h exp %h", i, g, e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        dly_a = 3; clear_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int i = 0; i < 300 && starts_a < 7; i++) tick();
        n_checks++; if (starts_a != 7) begin n_fail++; $display("FAIL rstmid_reach got %0d starts exp 7", starts_a); end
        rst = 1'b1; tick();
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy_a); end
        n_checks++; if (bus_a.tx_data !== 8'd0) begin n_fail++; $display("FAIL rstmid_tx_data got %h exp 0", bus_a.tx_data); end
        n_checks++; if (bus_a.mem_addr !== 32'd0) begin n_fail++; $display("FAIL rstmid_addr got %h exp 0", bus_a.mem_addr); end
        rst = 1'b0;
        repeat (6) tick();
        n_checks++; if (starts_a != 7) begin n_fail++; $display("FAIL rstmid_no_more_starts got %0d exp 7", starts_a); end
        clear_a(); push_exp_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int i = 0; i < 300 && dones_a == 0; i++) tick();
        n_checks++; if (dones_a == 0) begin n_fail++; $display("FAIL rstmid_timeout got no done exp done"); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e; logic [31:0] ea;
            e = exp_a.pop_front(); ea = eaddr_a.pop_front();
            n_checks++;
            if (obs_a.size() == 0) begin n_fail++; $display("FAIL rstmid_byte%0d got none exp %h", i, e); end
            else begin
                logic [7:0] g; logic [31:0] ga;
                g = obs_a.pop_front(); ga = oaddr_a.pop_front();
                if (g !== e || ga !== ea) begin n_fail++; $display("FAIL rstmid_byte%0d got %h@%h exp %h@%h", i, g, ga, e, ea); end
            end
        end
    endtask

    task automatic test_single_word();
        mem_b = 32'hFFFF0000;
        for (int b = 0; b < 4; b++) exp_b.push_back(mem_b[8*b +: 8]);
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int i = 0; i < 200 && dones_b == 0; i++) tick();
        n_checks++; if (dones_b == 0) begin n_fail++; $display("FAIL single_timeout got no done exp done"); end
        repeat (3) tick();
        n_checks++; if (starts_b != 4) begin n_fail++; $display("FAIL single_tx_starts got %0d exp 4", starts_b); end
        n_checks++; if (dones_b != 1) begin n_fail++; $display("FAIL single_done_pulses got %0d exp 1", dones_b); end
        n_checks++; if (done_cyc_b != last_txd_b + 1) begin n_fail++; $display("FAIL single_done_timing got cycle %0d exp %0d", done_cyc_b, last_txd_b + 1); end
        n_checks++; if (bus_b.mem_addr !== 32'd0) begin n_fail++; $display("FAIL single_addr got %h exp 0", bus_b.mem_addr); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = exp_b.pop_front();
            n_checks++;
            if (obs_b.size() == 0) begin n_fail++; $display("FAIL single_byte%0d got none exp %h", i, e); end
            else begin
                logic [7:0] g;
                g = obs_b.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL single_byte%0d got %h exp %h", i, g, e); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; xdone_a = 1'b0; dly_a = 3;
        mem_a[0] = 32'h11223344;
        mem_a[1] = 32'hA5B6C7D8;
        mem_b    = 32'h0;
        test_reset();
        test_slow_tx();
        test_fast_tx();
        test_ignored();
        test_reset_mid();
        test_single_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
